// File: rtl/theta_host_driver.sv
// theta_host_driver: host-side driver for the theta-step core.
// Buffers one state, feeds slices on request, captures the result stream.
module theta_host_driver #(
    parameter int WIDTH  = 25,
    parameter int PAGES  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [WIDTH-1:0]  wrData,
    input  logic              go,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [WIDTH-1:0]  rdData,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              coreStart,
    input  logic              coreReady,
    input  logic              corePutInput,
    output logic [WIDTH-1:0]  coreDin,
    input  logic              coreOutReady,
    input  logic [WIDTH-1:0]  coreDout
);

    localparam logic [ADDR_W:0] PAGES_C = (ADDR_W+1)'(PAGES);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(PAGES - 1);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        START,
        FEED,
        COLLECT,
        DONE
    } stateT;

    stateT state;
    stateT stateNext;

    logic [WIDTH-1:0] inBuf  [PAGES];
    logic [WIDTH-1:0] outBuf [PAGES];

    logic [ADDR_W:0]  inCnt;
    logic [ADDR_W:0]  outCnt;
    logic             errQ;
    logic [WIDTH-1:0] coreDinQ;

    logic accept;
    logic feedLoad;
    logic outWrite;
    logic errSet;
    logic countBad;

    assign countBad = (inCnt != PAGES_C);

    // Next-state and per-cycle control strobes.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        feedLoad  = 1'b0;
        outWrite  = 1'b0;
        errSet    = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    stateNext = WAIT_RDY;
                    accept    = 1'b1;
                end
            end
            WAIT_RDY: begin
                if (coreReady) begin
                    stateNext = START;
                end
            end
            START: begin
                stateNext = FEED;
            end
            FEED: begin
                if (corePutInput) begin
                    if (inCnt < PAGES_C) begin
                        feedLoad = 1'b1;
                    end else begin
                        errSet = 1'b1;
                    end
                end
                if (coreOutReady) begin
                    stateNext = COLLECT;
                end
            end
            COLLECT: begin
                outWrite = 1'b1;
                if (corePutInput || coreOutReady) begin
                    errSet = 1'b1;
                end
                if (outCnt == LAST_C) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
                if (countBad) begin
                    errSet = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Slice counters, sticky error and the registered core input slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            inCnt    <= '0;
            outCnt   <= '0;
            errQ     <= 1'b0;
            coreDinQ <= '0;
        end else begin
            if (accept) begin
                inCnt  <= '0;
                outCnt <= '0;
                errQ   <= 1'b0;
            end
            if (errSet) begin
                errQ <= 1'b1;
            end
            if (feedLoad) begin
                coreDinQ <= inBuf[inCnt[ADDR_W-1:0]];
                inCnt    <= inCnt + ONE_C;
            end
            if (outWrite && (outCnt < PAGES_C)) begin
                outCnt <= outCnt + ONE_C;
            end
        end
    end

    // Host writes into the input buffer only while idle.
    always_ff @(posedge clk) begin
        if (wrEn && !busy) begin
            inBuf[wrAddr] <= wrData;
        end
    end

    // Result capture; a reset cycle leaves partial contents untouched.
    always_ff @(posedge clk) begin
        if (outWrite && !rst && (outCnt < PAGES_C)) begin
            outBuf[outCnt[ADDR_W-1:0]] <= coreDout;
        end
    end

    assign rdData    = outBuf[rdAddr];
    assign coreDin   = coreDinQ;
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign coreStart = (state == START) && !rst;
    assign err       = errQ || ((state == DONE) && countBad);

endmodule

// File: tb/tb_theta_host_driver.sv
// tb_theta_host_driver: random runs of a core model against a
// transaction-level expectation of buffers, flags and fed slices.
module tb_theta_host_driver;

    localparam int WIDTH  = 25;
    localparam int PAGES  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wrEn = 1'b0;
    logic [ADDR_W-1:0] wrAddr = '0;
    logic [WIDTH-1:0]  wrData = '0;
    logic              go = 1'b0;
    logic [ADDR_W-1:0] rdAddr = '0;
    logic [WIDTH-1:0]  rdData;
    logic              busy;
    logic              done;
    logic              err;
    logic              coreStart;
    logic              coreReady = 1'b0;
    logic              corePutInput = 1'b0;
    logic [WIDTH-1:0]  coreDin;
    logic              coreOutReady = 1'b0;
    logic [WIDTH-1:0]  coreDout = '0;

    theta_host_driver #(
        .WIDTH (WIDTH),
        .PAGES (PAGES),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wrEn        (wrEn),
        .wrAddr      (wrAddr),
        .wrData      (wrData),
        .go          (go),
        .rdAddr      (rdAddr),
        .rdData      (rdData),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .coreStart   (coreStart),
        .coreReady   (coreReady),
        .corePutInput(corePutInput),
        .coreDin     (coreDin),
        .coreOutReady(coreOutReady),
        .coreDout    (coreDout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chkOn = 1'b0;

    logic [WIDTH-1:0] inModel  [PAGES];
    logic [WIDTH-1:0] outModel [PAGES];
    bit               outValid [PAGES];
    logic [WIDTH-1:0] expDin   = '0;
    logic             expBusy  = 1'b0;
    logic             expStart = 1'b0;
    logic             expDone  = 1'b0;
    logic             expErr   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rdAddr = ADDR_W'($urandom_range(0, PAGES - 1));
    endtask

    always @(negedge clk) begin
        if (chkOn) begin
            chk("coreDin", coreDin, expDin);
            chk("busy", busy, expBusy);
            chk("coreStart", coreStart, expStart);
            chk("done", done, expDone);
            chk("err", err, expErr);
            if (outValid[rdAddr]) begin
                chk("rdData", rdData, outModel[rdAddr]);
            end
        end
    end

    task automatic writeSlice(input int idx, input logic [WIDTH-1:0] v);
        wrEn   = 1'b1;
        wrAddr = ADDR_W'(idx);
        wrData = v;
        tick();
        wrEn = 1'b0;
        inModel[idx] = v;
    endtask

    task automatic runOnce(input int nPuts, input int readyDelay,
                           input bit patA, input int rstAt,
                           input bit busyWr, input bit collErr,
                           input bit putWithOr, input bit goWr);
        logic [WIDTH-1:0] v;
        int gap;
        v = WIDTH'($urandom);
        go = 1'b1;
        if (goWr) begin
            wrEn   = 1'b1;
            wrAddr = '0;
            wrData = v;
        end
        tick();
        go   = 1'b0;
        wrEn = 1'b0;
        if (goWr) inModel[0] = v;
        expBusy = 1'b1;
        expErr  = 1'b0;
        repeat (readyDelay) tick();
        coreReady = 1'b1;
        tick();
        coreReady = 1'b0;
        expStart  = 1'b1;
        tick();
        expStart = 1'b0;
        for (int i = 0; i < nPuts; i++) begin
            corePutInput = 1'b1;
            if (putWithOr && i == nPuts - 1) coreOutReady = 1'b1;
            if (busyWr && i == 3) begin
                wrEn   = 1'b1;
                wrAddr = ADDR_W'(5);
                wrData = 25'h1FFFFFF;
                go     = 1'b1;
            end
            tick();
            corePutInput = 1'b0;
            coreOutReady = 1'b0;
            wrEn = 1'b0;
            go   = 1'b0;
            if (i < PAGES) expDin = inModel[i];
            else expErr = 1'b1;
            if (patA && i == 0) chk("din_first", coreDin, 32'd1);
            if (patA && i == 63) chk("din_last", coreDin, 32'd190);
            if (i == PAGES) begin
                chk("din_hold", coreDin, inModel[PAGES-1]);
                chk("err_extra", err, 32'd1);
            end
            gap = patA ? 3 : $urandom_range(0, 3);
            if (!(putWithOr && i == nPuts - 1)) repeat (gap) tick();
        end
        if (!putWithOr) begin
            coreOutReady = 1'b1;
            tick();
            coreOutReady = 1'b0;
        end
        for (int j = 0; j < PAGES; j++) begin
            coreDout = patA ? (25'h1000000 | WIDTH'(j)) : WIDTH'($urandom);
            if (collErr && j == 10) corePutInput = 1'b1;
            if (rstAt == j) rst = 1'b1;
            tick();
            corePutInput = 1'b0;
            if (rstAt == j) begin
                rst     = 1'b0;
                expBusy = 1'b0;
                expErr  = 1'b0;
                expDin  = '0;
                chk("rst_busy", busy, 32'd0);
                chk("rst_done", done, 32'd0);
                chk("rst_err", err, 32'd0);
                chk("rst_din", coreDin, 32'd0);
                return;
            end
            outModel[j] = coreDout;
            outValid[j] = 1'b1;
            if (collErr && j == 10) expErr = 1'b1;
        end
        expBusy = 1'b0;
        expDone = 1'b1;
        if (nPuts < PAGES) expErr = 1'b1;
        chk("done_pulse", done, 32'd1);
        if (nPuts != PAGES) chk("err_count", err, 32'd1);
        tick();
        expDone = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < PAGES; i++) outValid[i] = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset_busy", busy, 32'd0);
        chk("reset_done", done, 32'd0);
        chk("reset_err", err, 32'd0);
        chk("reset_start", coreStart, 32'd0);
        chk("reset_din", coreDin, 32'd0);
        chkOn = 1'b1;

        for (int i = 0; i < PAGES; i++) writeSlice(i, WIDTH'(i * 3 + 1));
        runOnce(64, 0, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        rdAddr = ADDR_W'(0);
        #1 chk("rd0", rdData, 32'h1000000);
        rdAddr = ADDR_W'(31);
        #1 chk("rd31", rdData, 32'h100001F);
        rdAddr = ADDR_W'(63);
        #1 chk("rd63", rdData, 32'h100003F);
        chk("errA", err, 32'd0);

        runOnce(64, 10, 1'b0, -1, 1'b1, 1'b0, 1'b0, 1'b0);
        runOnce(65, 2, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        runOnce(63, 1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < PAGES; i++) writeSlice(i, WIDTH'($urandom));
        runOnce(64, 3, 1'b0, 20, 1'b0, 1'b0, 1'b0, 1'b0);
        runOnce(64, 0, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b1);
        runOnce(64, 2, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        runOnce(64, $urandom_range(0, 5), 1'b0, -1,
                1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();

        chkOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
